// File: rtl/stream_mux_rr_if.sv
// Bundles the per-channel input handshakes and the registered output stream
// of stream_mux_rr; master drives inputs/out_ready, slave is the mux itself.
`timescale 1ns/1ps
interface stream_mux_rr_if #(
   parameter int N_CH     = 4,
   parameter int WIDTH    = 8,
   parameter int SEL_BITS = 2
);
   logic [N_CH-1:0]       in_valid;
   logic [N_CH-1:0]       in_ready;
   logic [N_CH*WIDTH-1:0] in_data;
   logic [N_CH-1:0]       in_last;
   logic                  out_valid;
   logic                  out_ready;
   logic [WIDTH-1:0]      out_data;
   logic                  out_last;
   logic [SEL_BITS-1:0]   out_sel;

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_last, out_sel
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_last, out_sel
   );
endinterface

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream mux with a registered output stage.
// Packets are never interleaved; arbitration is round-robin or fixed priority.
`timescale 1ns/1ps
module stream_mux_rr #(
   parameter int N_CH     = 4,
   parameter int WIDTH    = 8,
   parameter int SEL_BITS = 2,
   parameter int MODE     = 0
) (
   input  logic           clk,
   input  logic           rst,
   stream_mux_rr_if.slave bus
);
   // state     | meaning
   // ST_IDLE   | between packets, arbitrate among valid channels
   // ST_LOCKED | mid-packet, only lock_ch may transfer until its last beat
   typedef enum logic [0:0] {ST_IDLE, ST_LOCKED} state_t;

   state_t              state_q, state_d;
   logic [SEL_BITS-1:0] ptr_q, ptr_d;
   logic [SEL_BITS-1:0] lock_ch_q, lock_ch_d;
   logic                out_valid_q, out_valid_d;
   logic [WIDTH-1:0]    out_data_q, out_data_d;
   logic                out_last_q, out_last_d;
   logic [SEL_BITS-1:0] out_sel_q, out_sel_d;

   logic                load_en;
   logic [SEL_BITS-1:0] grant;
   logic                grant_vld;
   logic                beat_valid;
   logic [WIDTH-1:0]    beat_data;
   logic                beat_last;
   logic                xfer;
   logic [N_CH-1:0]     in_ready_w;
   int                  start_idx;

   assign load_en = !out_valid_q || bus.out_ready;

   // Scan from the farthest candidate down so the one nearest start_idx wins.
   always_comb begin
      grant     = '0;
      grant_vld = 1'b0;
      start_idx = (MODE == 0) ? int'(ptr_q) : 0;
      if (state_q == ST_LOCKED) begin
         grant     = lock_ch_q;
         grant_vld = 1'b1;
      end else begin
         for (int k = N_CH - 1; k >= 0; k--) begin
            for (int j = 0; j < N_CH; j++) begin
               if (bus.in_valid[j] &&
                   ((start_idx + k == j) || (start_idx + k - N_CH == j))) begin
                  grant     = SEL_BITS'(j);
                  grant_vld = 1'b1;
               end
            end
         end
      end
   end

   always_comb begin
      beat_valid = 1'b0;
      beat_data  = '0;
      beat_last  = 1'b0;
      in_ready_w = '0;
      for (int k = 0; k < N_CH; k++) begin
         if (grant == SEL_BITS'(k)) begin
            beat_valid    = bus.in_valid[k];
            beat_data     = bus.in_data[k*WIDTH +: WIDTH];
            beat_last     = bus.in_last[k];
            in_ready_w[k] = load_en && grant_vld && !rst;
         end
      end
   end

   assign xfer = grant_vld && load_en && beat_valid && !rst;

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      lock_ch_d   = lock_ch_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      out_sel_d   = out_sel_q;
      if (load_en) begin
         out_valid_d = 1'b0;
      end
      if (xfer) begin
         out_valid_d = 1'b1;
         out_data_d  = beat_data;
         out_last_d  = beat_last;
         out_sel_d   = grant;
         if (beat_last) begin
            state_d = ST_IDLE;
            // Pointer advances only at packet end, so single-beat packets rotate too.
            if (MODE == 0) begin
               ptr_d = (int'(grant) == N_CH - 1) ? '0 : grant + 1'b1;
            end
         end else begin
            state_d   = ST_LOCKED;
            lock_ch_d = grant;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         ptr_q       <= '0;
         lock_ch_q   <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         out_sel_q   <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         lock_ch_q   <= lock_ch_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         out_sel_q   <= out_sel_d;
      end
   end

   assign bus.in_ready  = in_ready_w;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_last  = out_last_q;
   assign bus.out_sel   = out_sel_q;

   a_ready_onehot: assert property (@(posedge clk) $onehot0(in_ready_w));
endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: a round-robin and a fixed-priority instance,
// per-channel source queues, and per-instance expected-beat scoreboards.
`timescale 1ns/1ps
module tb_stream_mux_rr;
   localparam int N_CH     = 4;
   localparam int WIDTH    = 8;
   localparam int SEL_BITS = 2;
   localparam int DEPTH    = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   stream_mux_rr_if #(.N_CH(N_CH), .WIDTH(WIDTH), .SEL_BITS(SEL_BITS)) bus_rr ();
   stream_mux_rr_if #(.N_CH(N_CH), .WIDTH(WIDTH), .SEL_BITS(SEL_BITS)) bus_fp ();

   stream_mux_rr #(.N_CH(N_CH), .WIDTH(WIDTH), .SEL_BITS(SEL_BITS), .MODE(0)) u_rr (
      .clk (clk),
      .rst (rst),
      .bus (bus_rr)
   );

   stream_mux_rr #(.N_CH(N_CH), .WIDTH(WIDTH), .SEL_BITS(SEL_BITS), .MODE(1)) u_fp (
      .clk (clk),
      .rst (rst),
      .bus (bus_fp)
   );

   int checks = 0;
   int errors = 0;

   logic [WIDTH:0]  src_mem [2][N_CH][DEPTH];
   int              src_wr  [2][N_CH];
   int              src_rd  [2][N_CH];
   logic [N_CH-1:0] fire    [2];
   logic [10:0]     exp_rr [$];
   logic [10:0]     exp_fp [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_src(input int d, input int ch, input logic [7:0] data, input logic last);
      src_mem[d][ch][src_wr[d][ch]] = {last, data};
      src_wr[d][ch]++;
   endtask

   task automatic push_exp(input int d, input logic [1:0] sel, input logic last, input logic [7:0] data);
      if (d == 0) exp_rr.push_back({sel, last, data});
      else        exp_fp.push_back({sel, last, data});
   endtask

   function automatic logic [N_CH-1:0] src_valid(input int d);
      logic [N_CH-1:0] v = '0;
      for (int c = 0; c < N_CH; c++) v[c] = (src_rd[d][c] < src_wr[d][c]);
      return v;
   endfunction

   function automatic logic [N_CH*WIDTH-1:0] src_data(input int d);
      logic [N_CH*WIDTH-1:0] v = '0;
      for (int c = 0; c < N_CH; c++)
         if (src_rd[d][c] < src_wr[d][c]) v[c*WIDTH +: WIDTH] = src_mem[d][c][src_rd[d][c]][WIDTH-1:0];
      return v;
   endfunction

   function automatic logic [N_CH-1:0] src_last(input int d);
      logic [N_CH-1:0] v = '0;
      for (int c = 0; c < N_CH; c++)
         if (src_rd[d][c] < src_wr[d][c]) v[c] = src_mem[d][c][src_rd[d][c]][WIDTH];
      return v;
   endfunction

   task automatic drive_inputs();
      bus_rr.in_valid = src_valid(0);
      bus_rr.in_data  = src_data(0);
      bus_rr.in_last  = src_last(0);
      bus_fp.in_valid = src_valid(1);
      bus_fp.in_data  = src_data(1);
      bus_fp.in_last  = src_last(1);
   endtask

   // Sources advance one cycle after an accepted beat, holding otherwise.
   always @(posedge clk) begin
      #1;
      for (int d = 0; d < 2; d++)
         for (int c = 0; c < N_CH; c++)
            if (fire[d][c]) src_rd[d][c]++;
      drive_inputs();
   end

   always @(negedge clk) begin
      fire[0] = bus_rr.in_valid & bus_rr.in_ready;
      fire[1] = bus_fp.in_valid & bus_fp.in_ready;
   end

   always @(negedge clk) begin
      logic [10:0] e;
      if (!rst && bus_rr.out_valid && bus_rr.out_ready) begin
         if (exp_rr.size() == 0) check("rr unexpected beat", {bus_rr.out_sel, bus_rr.out_last, bus_rr.out_data}, 32'hFFFF);
         else begin
            e = exp_rr.pop_front();
            check("rr beat sel/last/data", {bus_rr.out_sel, bus_rr.out_last, bus_rr.out_data}, e);
         end
      end
      if (!rst && bus_fp.out_valid && bus_fp.out_ready) begin
         if (exp_fp.size() == 0) check("fp unexpected beat", {bus_fp.out_sel, bus_fp.out_last, bus_fp.out_data}, 32'hFFFF);
         else begin
            e = exp_fp.pop_front();
            check("fp beat sel/last/data", {bus_fp.out_sel, bus_fp.out_last, bus_fp.out_data}, e);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_drain(input int d);
      int n = 0;
      while (((d == 0) ? exp_rr.size() : exp_fp.size()) != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check((d == 0) ? "rr drain" : "fp drain", (d == 0) ? exp_rr.size() : exp_fp.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int d = 0; d < 2; d++)
         for (int c = 0; c < N_CH; c++) begin
            src_wr[d][c] = 0;
            src_rd[d][c] = 0;
         end
      fire[0] = '0;
      fire[1] = '0;
      drive_inputs();
      bus_rr.out_ready = 1'b1;
      bus_fp.out_ready = 1'b1;

      // reset values
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rr rst out_valid", bus_rr.out_valid, 0);
      check("rr rst out_data",  bus_rr.out_data,  0);
      check("rr rst out_last",  bus_rr.out_last,  0);
      check("rr rst out_sel",   bus_rr.out_sel,   0);
      check("rr rst in_ready",  bus_rr.in_ready,  0);
      check("fp rst out_valid", bus_fp.out_valid, 0);
      check("fp rst out_data",  bus_fp.out_data,  0);
      check("fp rst in_ready",  bus_fp.in_ready,  0);
      step();
      rst = 1'b0;

      // all four channels, single-beat packets: sel 0,1,2,3,0,1 back to back
      step();
      push_src(0, 0, 8'h10, 1'b1); push_src(0, 0, 8'h11, 1'b1);
      push_src(0, 1, 8'h20, 1'b1); push_src(0, 1, 8'h21, 1'b1);
      push_src(0, 2, 8'h30, 1'b1);
      push_src(0, 3, 8'h40, 1'b1);
      push_exp(0, 2'd0, 1'b1, 8'h10); push_exp(0, 2'd1, 1'b1, 8'h20);
      push_exp(0, 2'd2, 1'b1, 8'h30); push_exp(0, 2'd3, 1'b1, 8'h40);
      push_exp(0, 2'd0, 1'b1, 8'h11); push_exp(0, 2'd1, 1'b1, 8'h21);
      @(posedge clk);
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         @(negedge clk);
         check("rr throughput out_valid", bus_rr.out_valid, 1);
      end
      @(posedge clk);
      @(negedge clk);
      check("rr idle out_valid", bus_rr.out_valid, 0);

      // only ch2 valid, one beat 0xA5 with last
      step();
      push_src(0, 2, 8'hA5, 1'b1);
      push_exp(0, 2'd2, 1'b1, 8'hA5);
      @(posedge clk);
      @(negedge clk);
      check("rr ch2 in_ready", bus_rr.in_ready, 4'b0100);
      @(posedge clk);
      @(negedge clk);
      check("rr ch2 out_valid", bus_rr.out_valid, 1);
      check("rr ch2 out_data",  bus_rr.out_data,  8'hA5);
      check("rr ch2 out_sel",   bus_rr.out_sel,   2);
      check("rr ch2 out_last",  bus_rr.out_last,  1);
      wait_drain(0);

      // back-pressure: 0x3C held for three stalled clocks
      step();
      bus_rr.out_ready = 1'b0;
      push_src(0, 3, 8'h3C, 1'b1); push_src(0, 3, 8'h3D, 1'b1);
      push_src(0, 0, 8'hC0, 1'b1);
      push_exp(0, 2'd3, 1'b1, 8'h3C); push_exp(0, 2'd0, 1'b1, 8'hC0);
      push_exp(0, 2'd3, 1'b1, 8'h3D);
      @(posedge clk);
      @(posedge clk);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rr stall out_data",  bus_rr.out_data,  8'h3C);
         check("rr stall out_valid", bus_rr.out_valid, 1);
         check("rr stall in_ready",  bus_rr.in_ready,  0);
         @(posedge clk);
      end
      #2;
      bus_rr.out_ready = 1'b1;
      wait_drain(0);

      // ch1 three-beat packet while ch0 waits
      step();
      push_src(0, 1, 8'h51, 1'b0); push_src(0, 1, 8'h52, 1'b0); push_src(0, 1, 8'h53, 1'b1);
      push_exp(0, 2'd1, 1'b0, 8'h51); push_exp(0, 2'd1, 1'b0, 8'h52);
      push_exp(0, 2'd1, 1'b1, 8'h53); push_exp(0, 2'd0, 1'b1, 8'h0A);
      step();
      push_src(0, 0, 8'h0A, 1'b1);
      @(posedge clk);
      @(negedge clk);
      check("rr lock in_ready", bus_rr.in_ready, 4'b0010);
      @(posedge clk);
      @(negedge clk);
      check("rr lock in_ready", bus_rr.in_ready, 4'b0010);
      wait_drain(0);

      // reset in the middle of a ch2 packet
      step();
      push_src(0, 2, 8'h21, 1'b0);
      push_exp(0, 2'd2, 1'b0, 8'h21);
      step();
      push_src(0, 0, 8'h01, 1'b1);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      check("rr bubble in_ready", bus_rr.in_ready, 4'b0100);
      step();
      push_src(0, 2, 8'h22, 1'b0);
      bus_rr.out_ready = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      check("rr pre-rst out_data",  bus_rr.out_data,  8'h22);
      check("rr pre-rst out_valid", bus_rr.out_valid, 1);
      check("rr pre-rst in_ready",  bus_rr.in_ready,  0);
      step();
      rst = 1'b1;
      bus_rr.out_ready = 1'b1;
      push_src(0, 2, 8'h25, 1'b1);
      push_exp(0, 2'd0, 1'b1, 8'h01); push_exp(0, 2'd2, 1'b1, 8'h25);
      @(negedge clk);
      check("rr in_ready under rst", bus_rr.in_ready, 0);
      @(posedge clk);
      #2;
      rst = 1'b0;
      @(negedge clk);
      check("rr post-rst out_valid", bus_rr.out_valid, 0);
      check("rr post-rst in_ready",  bus_rr.in_ready,  4'b0001);
      wait_drain(0);

      // fixed priority: ch0 streams, ch3 starves until ch0 runs dry
      step();
      for (int i = 0; i < 6; i++) push_src(1, 0, 8'h61 + 8'(i), 1'b1);
      push_src(1, 3, 8'hF0, 1'b1);
      for (int i = 0; i < 6; i++) push_exp(1, 2'd0, 1'b1, 8'h61 + 8'(i));
      push_exp(1, 2'd3, 1'b1, 8'hF0);
      @(posedge clk);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("fp priority in_ready", bus_fp.in_ready, 4'b0001);
         @(posedge clk);
      end
      wait_drain(1);

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
